dt_repack: RTL

DT_REPACK -- requirements
Module: dt_repack

---
 rtl/dt_pkg.sv | 24 ++
 rtl/dt_pack16.sv | 57 +++++
 rtl/dt_repack.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dt_pkg.sv
// ============================================================================
// Module : dt_pkg
// Brief  : Shared types and sizes for the distance-map repacker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dt_pkg;

  localparam int IMG_PIX = 16384;
  localparam int WORDS   = 1024;
  localparam int RES_AW  = 14;
  localparam int STO_AW  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } dt_state_e;

endpackage

`default_nettype wire

// File: rtl/dt_pack16.sv
// ============================================================================
// Module : dt_pack16
// Brief  : MSB-first 16-pixel shift packer; word_valid pulses with each word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dt_pack16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        shift_en,
  input  logic        bit_in,
  output logic        word_valid,
  output logic [15:0] word
);

  logic [14:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] word_q, word_d;
  logic        valid_q, valid_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (shift_en) begin
      shift_d = {shift_q[13:0], bit_in};
      cnt_d   = cnt_q + 4'd1;
      // Sixteenth pixel completes the word; the first pixel ends up at bit 15.
      if (cnt_q == 4'hF) begin
        word_d  = {shift_q, bit_in};
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid = valid_q;
  assign word       = word_q;

endmodule

`default_nettype wire

// File: rtl/dt_repack.sv
// ============================================================================
// Module : dt_repack
// Brief  : Thresholds a distance map and repacks it into 16-pixel words.
//          Optional statistics ports enabled by macro DT_REPACK_STAT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dt_repack
  import dt_pkg::*;
#(
  parameter int unsigned THRESH = 0,
  parameter int unsigned IMG_W  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  input  logic [7:0]        res_di,
  output logic              sto_wr,
  output logic [STO_AW-1:0] sto_addr,
  output logic [15:0]       sto_do,
  output logic              done
`ifdef DT_REPACK_STAT_EN
  ,
  output logic [14:0]       obj_cnt,
  output logic [7:0]        max_dist
`endif
);

  localparam logic [7:0]        THR8      = 8'(THRESH);
  localparam logic [RES_AW-1:0] LAST_ADDR = RES_AW'((IMG_PIX / IMG_W) * IMG_W - 1);
  localparam logic [STO_AW-1:0] LAST_WORD = STO_AW'(WORDS - 1);

  dt_state_e         state_q, state_d;
  logic              res_rd_q, res_rd_d;
  logic [RES_AW-1:0] res_addr_q, res_addr_d;
  logic              cap_vld_q, cap_vld_d;
  logic [RES_AW-1:0] cap_addr_q, cap_addr_d;
  logic [STO_AW-1:0] sto_addr_q, sto_addr_d;
  logic              done_q, done_d;

  logic start_acc;
  logic pix_bit;
  logic word_end;

  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign pix_bit   = (res_di > THR8);
  assign word_end  = cap_vld_q && (cap_addr_q[3:0] == 4'hF);

  always_comb begin
    state_d    = state_q;
    res_rd_d   = res_rd_q;
    res_addr_d = res_addr_q;
    done_d     = done_q;
    // Read data returns one cycle after the request; track which pixel it is.
    cap_vld_d  = res_rd_q;
    cap_addr_d = res_addr_q;
    sto_addr_d = word_end ? cap_addr_q[RES_AW-1:4] : sto_addr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          res_rd_d   = 1'b1;
          res_addr_d = '0;
          done_d     = 1'b0;
        end
      end
      ST_RUN: begin
        if (res_addr_q == LAST_ADDR) begin
          state_d  = ST_FLUSH;
          res_rd_d = 1'b0;
        end else begin
          res_addr_d = res_addr_q + 14'd1;
        end
      end
      ST_FLUSH: begin
        if (sto_wr && (sto_addr_q == LAST_WORD)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      res_rd_q   <= 1'b0;
      res_addr_q <= '0;
      cap_vld_q  <= 1'b0;
      cap_addr_q <= '0;
      sto_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_rd_q   <= res_rd_d;
      res_addr_q <= res_addr_d;
      cap_vld_q  <= cap_vld_d;
      cap_addr_q <= cap_addr_d;
      sto_addr_q <= sto_addr_d;
      done_q     <= done_d;
    end
  end

  dt_pack16 u_pack (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (cap_vld_q),
    .bit_in     (pix_bit),
    .word_valid (sto_wr),
    .word       (sto_do)
  );

  assign res_rd   = res_rd_q;
  assign res_addr = res_addr_q;
  assign sto_addr = sto_addr_q;
  assign done     = done_q;

`ifdef DT_REPACK_STAT_EN
  logic [14:0] obj_cnt_q, obj_cnt_d;
  logic [7:0]  max_dist_q, max_dist_d;

  always_comb begin
    obj_cnt_d  = obj_cnt_q;
    max_dist_d = max_dist_q;
    if (start_acc) begin
      obj_cnt_d  = '0;
      max_dist_d = '0;
    end else if (cap_vld_q) begin
      obj_cnt_d = obj_cnt_q + {14'd0, pix_bit};
      if (res_di > max_dist_q) begin
        max_dist_d = res_di;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obj_cnt_q  <= '0;
      max_dist_q <= '0;
    end else begin
      obj_cnt_q  <= obj_cnt_d;
      max_dist_q <= max_dist_d;
    end
  end

  assign obj_cnt  = obj_cnt_q;
  assign max_dist = max_dist_q;
`else
  // start_acc only feeds the statistics block.
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

`default_nettype wire
